// File: rtl/chip_6502_bus_if.sv
// chip_6502 CPU-side bus bundle: address, direction and both data paths.
// The master is the CPU; the slave is the bus responder.
interface chip_6502_bus_if;
  logic [15:0] ab;
  logic        rw;
  logic [7:0]  dbo;
  logic [7:0]  dbi;

  modport master (output ab, rw, dbo, input dbi);
  modport slave  (input ab, rw, dbo, output dbi);
endinterface

// File: rtl/chip_6502_bus.sv
// chip_6502 bus responder: phi/reset sequencer plus mirrored RAM.
// Optional bus trace outputs with CHIP_6502_BUS_TRACE_EN.
module chip_6502_bus #(
  parameter int HALF_PERIOD  = 8,
  parameter int RESET_CYCLES = 8,
  parameter int RAM_AW       = 12
) (
  input  logic        clk,
  input  logic        res,
  input  logic        cpu_reset_req,
  output logic        phi,
  output logic        cpu_res,
  chip_6502_bus_if.slave bus,
  input  logic        ld_we,
  input  logic [15:0] ld_addr,
  input  logic [7:0]  ld_data,
  output logic        running,
  output logic [31:0] cycles
`ifdef CHIP_6502_BUS_TRACE_EN
  ,
  output logic        trace_valid,
  output logic [15:0] trace_addr,
  output logic [7:0]  trace_data,
  output logic        trace_rw
`endif
);

  localparam int CW = $clog2(HALF_PERIOD);
  localparam int HW = $clog2(RESET_CYCLES + 1);

  typedef enum logic {S_HOLD, S_RUN} state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic        phi_q, phi_d;
  logic        req_q, req_d;
  logic [7:0]  dbi_q, dbi_d;
  logic [31:0] cyc_q, cyc_d;
  logic [15:0] ab_lat_q, ab_lat_d;
  logic        rw_lat_q, rw_lat_d;

  logic [7:0]  mem [2**RAM_AW];

  logic              last, p1_end, fall, rd_load;
  logic              cpu_we, host_we;
  logic [RAM_AW-1:0] a_lat;

  assign last    = cnt_q == CW'(HALF_PERIOD - 1);
  assign p1_end  = !phi_q && last;
  assign fall    = phi_q && last;
  assign rd_load = phi_q && (cnt_q == '0) && rw_lat_q;
  assign a_lat   = ab_lat_q[RAM_AW-1:0];
  assign cpu_we  = fall && !rw_lat_q && (state_q == S_RUN);
  assign host_we = ld_we && (state_q == S_HOLD);

  // RAM has no reset; res gates both write ports so nothing lands mid-reset
  always_ff @(posedge clk) begin
    if (res && cpu_we)
      mem[a_lat] <= bus.dbo;
    else if (res && host_we)
      mem[ld_addr[RAM_AW-1:0]] <= ld_data;
  end

  always_comb begin
    cnt_d    = last ? '0 : cnt_q + 1'b1;
    phi_d    = last ? ~phi_q : phi_q;
    ab_lat_d = p1_end ? bus.ab : ab_lat_q;
    rw_lat_d = p1_end ? bus.rw : rw_lat_q;
    dbi_d    = rd_load ? mem[a_lat] : dbi_q;
    state_d  = state_q;
    hold_d   = hold_q;
    req_d    = req_q;
    cyc_d    = cyc_q;
    unique case (state_q)
      S_HOLD: begin
        req_d = 1'b0;
        if (cpu_reset_req) begin
          hold_d = '0;
        end else if (fall) begin
          if (hold_q == HW'(RESET_CYCLES - 1)) begin
            state_d = S_RUN;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        if (fall) begin
          // exiting cycle keeps the count unchanged
          if (req_q || cpu_reset_req) begin
            state_d = S_HOLD;
            hold_d  = '0;
            req_d   = 1'b0;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end else if (cpu_reset_req) begin
          req_d = 1'b1;
        end
      end
      default: state_d = S_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q  <= S_HOLD;
      cnt_q    <= '0;
      hold_q   <= '0;
      phi_q    <= 1'b0;
      req_q    <= 1'b0;
      dbi_q    <= 8'h00;
      cyc_q    <= '0;
      ab_lat_q <= '0;
      rw_lat_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      phi_q    <= phi_d;
      req_q    <= req_d;
      dbi_q    <= dbi_d;
      cyc_q    <= cyc_d;
      ab_lat_q <= ab_lat_d;
      rw_lat_q <= rw_lat_d;
    end
  end

  assign phi     = phi_q;
  assign cpu_res = state_q == S_RUN;
  assign running = state_q == S_RUN;
  assign cycles  = cyc_q;
  assign bus.dbi = dbi_q;

`ifdef CHIP_6502_BUS_TRACE_EN
  logic        tv_q, tv_d;
  logic [15:0] ta_q, ta_d;
  logic [7:0]  td_q, td_d;
  logic        tr_q, tr_d;

  always_comb begin
    tv_d = fall && (state_q == S_RUN);
    ta_d = tv_d ? ab_lat_q : ta_q;
    td_d = tv_d ? (rw_lat_q ? dbi_q : bus.dbo) : td_q;
    tr_d = tv_d ? rw_lat_q : tr_q;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      tv_q <= 1'b0;
      ta_q <= '0;
      td_q <= '0;
      tr_q <= 1'b0;
    end else begin
      tv_q <= tv_d;
      ta_q <= ta_d;
      td_q <= td_d;
      tr_q <= tr_d;
    end
  end

  assign trace_valid = tv_q;
  assign trace_addr  = ta_q;
  assign trace_data  = td_q;
  assign trace_rw    = tr_q;
`endif

  logic unused_ok;
  assign unused_ok = ^{ld_addr[15:RAM_AW], ab_lat_q[15:RAM_AW]};

endmodule
